// File: rtl/cache_fill_pkg.sv
// rtl/cache_fill_pkg.sv - shared FSM state type and width helpers for the cache fill arbiter
package cache_fill_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

    function automatic int off_width(input int line_words, input int data_w);
        return $clog2(line_words * data_w / 8);
    endfunction

    function automatic int idx_width(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int port_width(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

    function automatic int byte_shift(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/cache_fill_arb.sv
// rtl/cache_fill_arb.sv - combinational fixed-priority / round-robin grant (pointer held by parent)
module fill_arb
    import cache_fill_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int RR_MODE = 0,
    localparam int PORT_W = port_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    ptr,
    output logic [NUM_PORTS-1:0] grant_oh,
    output logic [PORT_W-1:0]    grant_idx,
    output logic                 grant_valid
);

    logic [PORT_W-1:0] fixed_idx;
    logic [PORT_W-1:0] rr_idx;

    always_comb begin
        fixed_idx = '0;
        rr_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req[i]) fixed_idx = PORT_W'(i);
        end
        // Walk backwards so the port nearest after ptr is written last and wins.
        for (int k = NUM_PORTS; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NUM_PORTS]) rr_idx = PORT_W'((int'(ptr) + k) % NUM_PORTS);
        end
        grant_valid = |req;
        grant_idx = (RR_MODE != 0) ? rr_idx : fixed_idx;
        for (int i = 0; i < NUM_PORTS; i++) begin
            grant_oh[i] = grant_valid && (grant_idx == PORT_W'(i));
        end
    end

endmodule

// File: rtl/cache_fill_arbiter.sv
// rtl/cache_fill_arbiter.sv - miss-service engine: arbitrates cache ports, sequences line fills and write-throughs
// Define CRITICAL_WORD_FIRST_EN to issue from the requested word and add the crit_valid output.
module cache_fill_arbiter
    import cache_fill_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int NUM_PORTS = 2,
    parameter int LINE_WORDS = 8,
    parameter int RR_MODE = 0,
    localparam int IDX_W = idx_width(LINE_WORDS),
    localparam int PORT_W = port_width(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS-1:0]        req_wr,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        port_stall,
    output logic [NUM_PORTS-1:0]        done,
    output logic                        fill_valid,
    output logic [PORT_W-1:0]           fill_port,
    output logic [IDX_W-1:0]            fill_idx,
    output logic [DATA_W-1:0]           fill_data,
    output logic                        mem_en,
    output logic                        mem_wr,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_rvalid,
    input  logic [DATA_W-1:0]           mem_rdata
`ifdef CRITICAL_WORD_FIRST_EN
    ,
    output logic                        crit_valid
`endif
);

    localparam int OFF_W = off_width(LINE_WORDS, DATA_W);
    localparam int BSH = byte_shift(DATA_W);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'((1 << BSH) - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFF_W) - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

    state_t                state_q, state_d;
    logic [PORT_W-1:0]     winner_q, rr_ptr_q, grant_idx;
    logic [NUM_PORTS-1:0]  grant_oh;
    logic                  grant_valid;
    logic [ADDR_W-1:0]     addr_q, sel_addr, line_base;
    logic [DATA_W-1:0]     wdata_q, sel_wdata;
    logic [IDX_W-1:0]      issue_cnt_q, ret_cnt_q, start_w, issue_word, ret_word;
    logic                  returning;

    fill_arb #(
        .NUM_PORTS(NUM_PORTS),
        .RR_MODE(RR_MODE)
    ) u_arb (
        .req(req_valid),
        .ptr(rr_ptr_q),
        .grant_oh(grant_oh),
        .grant_idx(grant_idx),
        .grant_valid(grant_valid)
    );

    always_comb begin
        sel_addr = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_oh[i]) begin
                sel_addr = sel_addr | req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = sel_wdata | req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef CRITICAL_WORD_FIRST_EN
    assign start_w = addr_q[OFF_W-1:BSH];
`else
    assign start_w = '0;
`endif

    // Counters are IDX_W wide, so adding the start word wraps modulo LINE_WORDS.
    assign issue_word = issue_cnt_q + start_w;
    assign ret_word = ret_cnt_q + start_w;
    assign line_base = addr_q & LINE_MASK;
    assign returning = mem_rvalid && (state_q == ISSUE || state_q == DRAIN);
    assign port_stall = req_valid & ~done;

`ifdef CRITICAL_WORD_FIRST_EN
    assign crit_valid = returning && (ret_cnt_q == '0);
`endif

    always_comb begin
        state_d = state_q;
        mem_en = 1'b0;
        mem_wr = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        done = '0;
        fill_valid = returning;
        fill_data = returning ? mem_rdata : '0;
        fill_idx = returning ? ret_word : '0;
        fill_port = returning ? winner_q : '0;
        case (state_q)
            IDLE: begin
                if (grant_valid) state_d = (|(req_wr & grant_oh)) ? WRITE : ISSUE;
            end
            ISSUE: begin
                mem_en = 1'b1;
                mem_addr = line_base | (ADDR_W'(issue_word) << BSH);
                if (issue_cnt_q == LAST_IDX) state_d = DRAIN;
            end
            DRAIN: begin
                if (returning && ret_cnt_q == LAST_IDX) state_d = DONE;
            end
            WRITE: begin
                mem_en = 1'b1;
                mem_wr = 1'b1;
                mem_addr = addr_q & WORD_MASK;
                mem_wdata = wdata_q;
                state_d = DONE;
            end
            DONE: begin
                done = NUM_PORTS'(1) << winner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            winner_q <= '0;
            rr_ptr_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && grant_valid) begin
                winner_q <= grant_idx;
                rr_ptr_q <= grant_idx;
                addr_q <= sel_addr;
                wdata_q <= sel_wdata;
                issue_cnt_q <= '0;
                ret_cnt_q <= '0;
            end else begin
                if (state_q == ISSUE) issue_cnt_q <= issue_cnt_q + 1'b1;
                if (returning) ret_cnt_q <= ret_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// tb/tb_cache_fill_arbiter.sv - self-checking bench for cache_fill_arbiter
module tb_cache_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req_valid, req_wr, port_stall, done;
    logic [31:0] req_addr, req_wdata;
    logic        fill_valid, mem_en, mem_wr, mem_rvalid;
    logic [0:0]  fill_port;
    logic [2:0]  fill_idx;
    logic [15:0] fill_data, mem_addr, mem_wdata, mem_rdata;

    logic [1:0]  rr_req_valid, rr_req_wr, rr_port_stall, rr_done;
    logic [31:0] rr_req_addr, rr_req_wdata;
    logic        rr_fill_valid, rr_mem_en, rr_mem_wr;
    logic        rr_mem_rvalid = 1'b0;
    logic [0:0]  rr_fill_port;
    logic [2:0]  rr_fill_idx;
    logic [15:0] rr_fill_data, rr_mem_addr, rr_mem_wdata;
    logic [15:0] rr_mem_rdata = 16'h0;
`ifdef CRITICAL_WORD_FIRST_EN
    logic        crit_valid, rr_crit_valid;
`endif

    cache_fill_arbiter #(.RR_MODE(0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .port_stall(port_stall), .done(done),
        .fill_valid(fill_valid), .fill_port(fill_port), .fill_idx(fill_idx), .fill_data(fill_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef CRITICAL_WORD_FIRST_EN
        , .crit_valid(crit_valid)
`endif
    );

    cache_fill_arbiter #(.RR_MODE(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req_valid(rr_req_valid), .req_wr(rr_req_wr),
        .req_addr(rr_req_addr), .req_wdata(rr_req_wdata), .port_stall(rr_port_stall), .done(rr_done),
        .fill_valid(rr_fill_valid), .fill_port(rr_fill_port), .fill_idx(rr_fill_idx), .fill_data(rr_fill_data),
        .mem_en(rr_mem_en), .mem_wr(rr_mem_wr), .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
        .mem_rvalid(rr_mem_rvalid), .mem_rdata(rr_mem_rdata)
`ifdef CRITICAL_WORD_FIRST_EN
        , .crit_valid(rr_crit_valid)
`endif
    );

    // Pipelined memory, latency 4, read data = address ^ 0x5A5A.
    logic [3:0]  mv = 4'b0;
    logic [15:0] md [4];
    logic        inj = 1'b0;
    assign mem_rvalid = mv[3] | inj;
    assign mem_rdata = md[3];
    always @(posedge clk) begin
        mv <= {mv[2:0], mem_en & ~mem_wr};
        md[0] <= mem_addr ^ 16'h5A5A;
        for (int i = 1; i < 4; i++) md[i] <= md[i-1];
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          port;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] base;
        int          done_cyc;
        int          drop_at;
        bit          inj;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input int v, input vec_t r);
        int  start, j, idx;
        bit  cur, exp_en, exp_fv;
        start = 0;
`ifdef CRITICAL_WORD_FIRST_EN
        if (!r.wr) start = int'(r.addr[3:1]);
`endif
        @(posedge clk); #1;
        req_valid = 2'b00;
        req_valid[r.port] = 1'b1;
        req_wr[r.port] = r.wr;
        req_addr[r.port*16 +: 16] = r.addr;
        req_wdata[r.port*16 +: 16] = r.wdata;
        inj = r.inj;
        cur = 1'b1;
        for (int t = 0; t <= r.done_cyc; t++) begin
            @(negedge clk);
            exp_en = r.wr ? (t == 1) : (t >= 1 && t <= 8);
            exp_fv = !r.wr && t >= 5 && t <= 12;
            chk($sformatf("v%0d t%0d stall", v, t), port_stall[r.port], cur && t != r.done_cyc);
            chk($sformatf("v%0d t%0d done", v, t), done, (t == r.done_cyc) ? (1 << r.port) : 0);
            chk($sformatf("v%0d t%0d mem_en", v, t), mem_en, exp_en);
            chk($sformatf("v%0d t%0d mem_wr", v, t), mem_wr, r.wr && t == 1);
            if (exp_en)
                chk($sformatf("v%0d t%0d mem_addr", v, t), mem_addr,
                    r.wr ? r.base : (r.base | (((start + t - 1) % 8) << 1)));
            if (r.wr && t == 1)
                chk($sformatf("v%0d t%0d mem_wdata", v, t), mem_wdata, r.wdata);
            chk($sformatf("v%0d t%0d fill_valid", v, t), fill_valid, exp_fv);
            if (exp_fv) begin
                j = t - 5;
                idx = (start + j) % 8;
                chk($sformatf("v%0d t%0d fill_idx", v, t), fill_idx, idx);
                chk($sformatf("v%0d t%0d fill_data", v, t), fill_data, (r.base | (idx << 1)) ^ 16'h5A5A);
                chk($sformatf("v%0d t%0d fill_port", v, t), fill_port, r.port);
`ifdef CRITICAL_WORD_FIRST_EN
                chk($sformatf("v%0d t%0d crit_valid", v, t), crit_valid, j == 0);
`endif
            end
            @(posedge clk); #1;
            if (t == r.drop_at || t == r.done_cyc) begin
                req_valid[r.port] = 1'b0;
                cur = 1'b0;
            end
        end
        inj = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1);
    end

    initial begin
        bit seen;
        int ng;
        int grants[4];

        vecs[0] = '{0, 1'b0, 16'h1234, 16'h0000, 16'h1230, 13, -1, 1'b0};
        vecs[1] = '{1, 1'b0, 16'hFFF7, 16'h0000, 16'hFFF0, 13, -1, 1'b0};
        vecs[2] = '{1, 1'b1, 16'h2001, 16'hBEEF, 16'h2000, 2, -1, 1'b1};
        vecs[3] = '{0, 1'b1, 16'hFFFF, 16'h1357, 16'hFFFE, 2, -1, 1'b1};
        vecs[4] = '{0, 1'b0, 16'h0008, 16'h0000, 16'h0000, 13, 3, 1'b0};

        req_valid = 2'b0; req_wr = 2'b0; req_addr = '0; req_wdata = '0;
        rr_req_valid = 2'b0; rr_req_wr = 2'b11;
        rr_req_addr = {16'h0020, 16'h0010}; rr_req_wdata = {16'hBBBB, 16'hAAAA};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset mem_en", mem_en, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset done", done, 0);
        chk("reset fill_valid", fill_valid, 0);
        chk("reset fill_port", fill_port, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle mem_en", mem_en, 0);
        chk("idle stall", port_stall, 0);

        for (int v = 0; v < 5; v++) run_vec(v, vecs[v]);

        // Simultaneous fills, fixed priority: port 1 first, port 0 after one idle bubble.
        @(posedge clk); #1;
        req_valid = 2'b11; req_wr = 2'b00; req_addr = {16'h0200, 16'h0100};
        @(negedge clk);
        chk("sim grant cycle mem_en", mem_en, 0);
        chk("sim grant cycle stall", port_stall, 2'b11);
        @(negedge clk);
        chk("sim first mem_en", mem_en, 1);
        chk("sim first addr", mem_addr, 16'h0200);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            chk("sim p0 stall during p1", port_stall[0], 1);
            chk("sim no done0 during p1", done[0], 0);
            if (done[1]) seen = 1'b1;
        end
        chk("sim done1 seen", seen, 1);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        @(negedge clk);
        chk("sim bubble mem_en", mem_en, 0);
        chk("sim bubble stall0", port_stall[0], 1);
        @(negedge clk);
        chk("sim second mem_en", mem_en, 1);
        chk("sim second addr", mem_addr, 16'h0100);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (done[0]) seen = 1'b1;
            else chk("sim p0 stall until done", port_stall[0], 1);
        end
        chk("sim done0 seen", seen, 1);
        @(posedge clk); #1 req_valid = 2'b00;

        // Stray return in IDLE must not surface as fill data.
        @(posedge clk); #1 inj = 1'b1;
        @(negedge clk);
        chk("idle rvalid fill_valid", fill_valid, 0);
        chk("idle rvalid fill_data", fill_data, 0);
        @(posedge clk); #1 inj = 1'b0;

        // Round-robin writes: port 0 alone first, then both continuously.
        rr_req_valid = 2'b01;
        @(posedge clk); #1 rr_req_valid = 2'b11;
        ng = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            @(negedge clk);
            chk("rr fill_valid", rr_fill_valid, 0);
            if (rr_done != 2'b00) begin
                grants[ng] = rr_done[1] ? 1 : 0;
                ng++;
            end
        end
        chk("rr four grants", ng, 4);
        for (int g = 0; g < 4 && g < ng; g++)
            chk($sformatf("rr grant %0d", g), grants[g], g % 2);
        @(posedge clk); #1 rr_req_valid = 2'b00;

        // Reset asserted at T7 of a fill.
        @(posedge clk); #1;
        req_valid = 2'b01; req_wr = 2'b00; req_addr = {16'h0000, 16'h1234};
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0; req_valid = 2'b00;
        #1;
        chk("rst mid mem_en", mem_en, 0);
        chk("rst mid mem_addr", mem_addr, 0);
        chk("rst mid fill_valid", fill_valid, 0);
        chk("rst mid done", done, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("post rst c%0d fill_valid", c), fill_valid, 0);
            chk($sformatf("post rst c%0d done", c), done, 0);
            chk($sformatf("post rst c%0d mem_en", c), mem_en, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
